// File: rtl/sdp_ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sdp_ram_pkg;

    // Two-state controller: initial fill of every word, then normal service.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Constant OR-ed into every address-derived fill word.
    localparam logic [19:0] FILL_CONST = 20'h55000;
    // Left shift applied to the address copy inside a fill word.
    localparam int          PAT_SHIFT  = 20;

    // Address-derived fill word before truncation to the data width.
    function automatic logic [63:0] fill_word(input logic [31:0] k);
        return {32'b0, k} | ({32'b0, k} << PAT_SHIFT) | {44'b0, FILL_CONST};
    endfunction

endpackage

// File: rtl/sdp_ram_array.sv
// Storage array with one write port and one synchronous read-first read port.
// Latency: read data registered, valid 1 cycle after the read enable edge.
// Backpressure: none; read data register holds its value while re_i is low.
module sdp_ram_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array contents are deliberately not reset; the fill sequence initialises them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register samples the pre-write contents, giving read-first collisions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdp_ram_responder.sv
// SDP RAM responder: fills all words after reset, then serves reads/writes; SDP_RAM_OUTREG_EN adds an output stage.
// Latency: read data and RVALID_o/COLL_o 1 cycle after REN_i (2 with SDP_RAM_OUTREG_EN).
// Backpressure: none; requests are ignored while BUSY_o is high, RDATA_o holds between reads.
module sdp_ram_responder
    import sdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 36,
    parameter int INIT_PATTERN = 1
) (
    input  logic                  clock0,
    input  logic                  RESET_ni,
    input  logic                  WEN_i,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR_i,
    input  logic [DATA_WIDTH-1:0] WDATA_i,
    input  logic                  REN_i,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR_i,
    output logic [DATA_WIDTH-1:0] RDATA_o,
    output logic                  RVALID_o,
    output logic                  BUSY_o,
    output logic                  COLL_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rvalid_q, coll_q;
    logic                  run;
    logic                  arr_we, arr_re, coll_d;
    logic [ADDR_WIDTH-1:0] arr_waddr;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata, fill_dat;

    assign run = (state_q == RUN);

    // Fill word for the current counter value, truncated to the word width.
    assign fill_dat = (INIT_PATTERN != 0) ? DATA_WIDTH'(fill_word(32'(cnt_q))) : '0;

    // During FILL the counter owns the write port and user requests are dropped.
    assign arr_we    = ~run | WEN_i;
    assign arr_waddr = run ? WR_ADDR_i : cnt_q;
    assign arr_wdata = run ? WDATA_i : fill_dat;
    assign arr_re    = run & REN_i;
    assign coll_d    = arr_re & WEN_i & (WR_ADDR_i == RD_ADDR_i);

    // Next state: step through every address once, leave FILL on the all-ones word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == FILL) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = RUN;
            end
        end
    end

    // Controller state and first-stage read flags.
    always_ff @(posedge clock0 or negedge RESET_ni) begin
        if (!RESET_ni) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= arr_re;
            coll_q   <= coll_d;
        end
    end

    sdp_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk_i   (clock0),
        .rst_ni  (RESET_ni),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .raddr_i (RD_ADDR_i),
        .rdata_o (arr_rdata)
    );

    assign BUSY_o = (state_q == FILL);

`ifdef SDP_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] rdata_out_q;
    logic                  rvalid_out_q, coll_out_q;

    // Extra output stage: data, valid and collision flag all retimed together.
    always_ff @(posedge clock0 or negedge RESET_ni) begin
        if (!RESET_ni) begin
            rdata_out_q  <= '0;
            rvalid_out_q <= 1'b0;
            coll_out_q   <= 1'b0;
        end else begin
            rdata_out_q  <= arr_rdata;
            rvalid_out_q <= rvalid_q;
            coll_out_q   <= coll_q;
        end
    end

    assign RDATA_o  = rdata_out_q;
    assign RVALID_o = rvalid_out_q;
    assign COLL_o   = coll_out_q;
`else
    assign RDATA_o  = arr_rdata;
    assign RVALID_o = rvalid_q;
    assign COLL_o   = coll_q;
`endif

endmodule

// File: tb/tb_sdp_ram_responder.sv
// Scoreboard bench for sdp_ram_responder with a behavioural array model.
// Latency: expects 1-cycle reads, or 2 when SDP_RAM_OUTREG_EN is defined.
// Backpressure: none; the bench issues requests freely once BUSY_o drops.
module tb_sdp_ram_responder;

    localparam int AW    = 10;
    localparam int DW    = 36;
    localparam int DEPTH = 1 << AW;
`ifdef SDP_RAM_OUTREG_EN
    localparam int LAT      = 2;
    localparam int INIT_PAT = 0;
`else
    localparam int LAT      = 1;
    localparam int INIT_PAT = 1;
`endif

    typedef struct {
        logic [DW-1:0] dat;
        logic          coll;
        int            due;
    } exp_t;

    logic          clock0 = 1'b0;
    logic          RESET_ni;
    logic          WEN_i;
    logic [AW-1:0] WR_ADDR_i;
    logic [DW-1:0] WDATA_i;
    logic          REN_i;
    logic [AW-1:0] RD_ADDR_i;
    logic [DW-1:0] RDATA_o;
    logic          RVALID_o;
    logic          BUSY_o;
    logic          COLL_o;

    int            vectors     = 0;
    int            miscompares = 0;
    int            edge_cnt    = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_dat    = '0;
    exp_t          sb [$];

    sdp_ram_responder #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .INIT_PATTERN (INIT_PAT)
    ) dut (
        .clock0    (clock0),
        .RESET_ni  (RESET_ni),
        .WEN_i     (WEN_i),
        .WR_ADDR_i (WR_ADDR_i),
        .WDATA_i   (WDATA_i),
        .REN_i     (REN_i),
        .RD_ADDR_i (RD_ADDR_i),
        .RDATA_o   (RDATA_o),
        .RVALID_o  (RVALID_o),
        .BUSY_o    (BUSY_o),
        .COLL_o    (COLL_o)
    );

    always #5 clock0 = ~clock0;

    always @(posedge clock0) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Expected contents after a completed fill, straight from the fill rule.
    task automatic model_fill();
        for (int k = 0; k < DEPTH; k++) begin
            logic [63:0] w;
            w = 64'(k) | (64'(k) << 20) | 64'h55000;
            model[k] = (INIT_PAT != 0) ? w[DW-1:0] : '0;
        end
    endtask

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic op(input bit wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit ren, input logic [AW-1:0] ra);
        exp_t e;
        WEN_i = wen; WR_ADDR_i = wa; WDATA_i = wd;
        REN_i = ren; RD_ADDR_i = ra;
        tick();
        if (ren) begin
            e.dat  = model[ra];
            e.coll = wen && (wa == ra);
            e.due  = edge_cnt + LAT - 1;
            sb.push_back(e);
        end
        if (wen) model[wa] = wd;
        WEN_i = 1'b0;
        REN_i = 1'b0;
    endtask

    task automatic rand_ops(input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0]   r;
            logic [AW-1:0] wa, ra;
            r  = {$urandom, $urandom};
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 15));
            op(1'($urandom_range(0, 1)), wa, r[DW-1:0], 1'($urandom_range(0, 1)), ra);
        end
    endtask

    // Counts cycles with BUSY_o high while throwing random requests at the block.
    task automatic fill_phase(input string name);
        int n;
        chk({name, "_busy_start"}, BUSY_o, 1);
        n = 0;
        while (BUSY_o && n < 2000) begin
            WEN_i     = 1'($urandom_range(0, 1));
            WR_ADDR_i = AW'($urandom_range(0, DEPTH - 1));
            WDATA_i   = DW'($urandom);
            REN_i     = 1'($urandom_range(0, 1));
            RD_ADDR_i = AW'($urandom_range(0, DEPTH - 1));
            tick();
            n++;
        end
        WEN_i = 1'b0;
        REN_i = 1'b0;
        chk({name, "_busy_cycles"}, n, DEPTH);
        model_fill();
    endtask

    task automatic check_reset_zero(input string name);
        chk({name, "_rdata"}, RDATA_o, 0);
        chk({name, "_rvalid"}, RVALID_o, 0);
        chk({name, "_coll"}, COLL_o, 0);
        chk({name, "_busy"}, BUSY_o, 1);
    endtask

    // Monitor: every cycle either a scoreboard entry is due or the outputs must idle.
    always @(negedge clock0) begin
        if (!RESET_ni) begin
            last_dat = '0;
        end else if (RVALID_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", RVALID_o, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_latency", edge_cnt, e.due);
                chk("rdata", RDATA_o, e.dat);
                chk("coll", COLL_o, e.coll);
                last_dat = e.dat;
            end
        end else begin
            chk("coll_without_rvalid", COLL_o, 0);
            chk("rdata_hold", RDATA_o, last_dat);
        end
    end

    initial begin
        RESET_ni  = 1'b0;
        WEN_i     = 1'b0;
        WR_ADDR_i = '0;
        WDATA_i   = '0;
        REN_i     = 1'b0;
        RD_ADDR_i = '0;
        #3;
        check_reset_zero("por");
        tick();
        tick();
        RESET_ni = 1'b1;
        fill_phase("fill0");

        // Fill readback, write-then-read, same-address collision, then re-read.
        op(1'b0, '0, '0, 1'b1, AW'('h003));
        op(1'b1, AW'('h010), DW'(36'h123456789), 1'b0, '0);
        op(1'b0, '0, '0, 1'b1, AW'('h010));
        op(1'b1, AW'('h020), DW'(36'hABC), 1'b1, AW'('h020));
        op(1'b0, '0, '0, 1'b1, AW'('h020));
        op(1'b1, AW'('h030), DW'(36'hF0F0F0F0F), 1'b1, AW'('h031));
        op(1'b0, '0, '0, 1'b1, AW'('h030));
        op(1'b0, '0, '0, 1'b1, AW'(DEPTH - 1));
        op(1'b0, '0, '0, 1'b1, AW'(DEPTH - 2));
        rand_ops(400);
        repeat (LAT + 2) tick();

        // Reset in RUN clears outputs at once; reset again part-way into the fill.
        RESET_ni = 1'b0;
        #1;
        check_reset_zero("rst_run");
        tick();
        RESET_ni = 1'b1;
        repeat (500) tick();
        chk("busy_mid_fill", BUSY_o, 1);
        RESET_ni = 1'b0;
        #1;
        check_reset_zero("rst_fill");
        tick();
        RESET_ni = 1'b1;
        fill_phase("fill1");

        op(1'b0, '0, '0, 1'b1, AW'('h003));
        op(1'b0, '0, '0, 1'b1, AW'('h010));
        rand_ops(150);
        repeat (LAT + 3) tick();
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
